// File: rtl/ysyx_22041207_iter_mul.sv
// Iterative shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW, valid/ready responder.
// Optional MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are all zero.
module ysyx_22041207_iter_mul #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic [1:0]      mul_signed,
  input  logic            mulw,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            mul_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic          neg_q;
  logic          w_q;
  logic [PW-1:0] a_q;
  logic [PW-1:0] acc_q;
  logic [XLEN-1:0] b_q;

  function automatic logic signed [XLEN-1:0] extend_op(input logic [XLEN-1:0] op,
                                                      input logic sgn,
                                                      input logic word);
    if (!word) return op;
    return {{(XLEN-32){sgn & op[31]}}, op[31:0]};
  endfunction

  // -2^(XLEN-1) maps onto 2^(XLEN-1), which still fits as an unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] op,
                                                input logic sgn);
    if (sgn && op[XLEN-1]) return $unsigned(-op);
    return $unsigned(op);
  endfunction

  function automatic logic [PW-1:0] sign_fix(input logic [PW-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // 2'b01 is not a legal encoding and degrades to fully unsigned.
  logic sign_a;
  logic sign_b;
  assign sign_a = mul_signed[1];
  assign sign_b = mul_signed[1] & mul_signed[0];

  logic signed [XLEN-1:0] ext_a;
  logic signed [XLEN-1:0] ext_b;
  logic [XLEN-1:0]        mag_a;
  logic [XLEN-1:0]        mag_b;
  logic                   neg_in;
  assign ext_a  = extend_op(multiplicand, sign_a, mulw);
  assign ext_b  = extend_op(multiplier, sign_b, mulw);
  assign mag_a  = magnitude(ext_a, sign_a);
  assign mag_b  = magnitude(ext_b, sign_b);
  assign neg_in = (sign_a & ext_a[XLEN-1]) ^ (sign_b & ext_b[XLEN-1]);

  logic accept;
  assign accept = (state == IDLE) & mul_valid & mul_ready & ~flush;

  logic [PW-1:0] acc_step;
  logic [PW-1:0] product;
  logic [CW-1:0] last_cnt;
  logic          last;
  assign acc_step = acc_q + (b_q[0] ? a_q : '0);
  assign product  = sign_fix(acc_step, neg_q);
  assign last_cnt = w_q ? CW'(31) : CW'(XLEN - 1);

`ifdef MUL_EARLY_OUT_EN
  assign last = (counter == last_cnt) || (b_q[XLEN-1:1] == '0);
`else
  assign last = (counter == last_cnt);
`endif

  // Datapath: operand shifters and accumulator, only meaningful while BUSY.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= {{XLEN{1'b0}}, mag_a};
      b_q   <= mag_b;
      acc_q <= '0;
    end else if (state == BUSY) begin
      acc_q <= acc_step;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mul_ready <= 1'b1;
      out_valid <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      counter   <= '0;
      neg_q     <= 1'b0;
      w_q       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      mul_ready <= 1'b1;
      out_valid <= 1'b0;
      counter   <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            mul_ready <= 1'b0;
            counter   <= '0;
            neg_q     <= neg_in;
            w_q       <= mulw;
          end
        end
        BUSY: begin
          counter <= counter + 1'b1;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (w_q) begin
              result_hi <= '0;
              result_lo <= {{(XLEN-32){product[31]}}, product[31:0]};
            end else begin
              result_hi <= product[PW-1:XLEN];
              result_lo <= product[XLEN-1:0];
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          mul_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          mul_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
